wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO, generalising the write pointer block. It keeps binary and Gray write pointers and synchronises the read-domain Gray pointer through a parametrised flop chain. It produces a same-cycle-accurate registered full, programmable almost_full, write-side occupancy and a sticky overflow flag. The block sits between the write-side user interface, the dual-port RAM write port and the read-domain synchroniser.

Parameters:
ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, number of synchroniser flops on the read pointer; legal range 2..4.

Ports:
clk  input  1  write-domain clock.
rst_n  input  1  asynchronous, active-low reset.
winc  input  1  write request from user.
rq_rptr_gray  input  ADDR_WIDTH+1  read pointer, Gray code, from read domain (asynchronous).
afull_thresh  input  ADDR_WIDTH+1  almost-full threshold in entries; quasi-static.
ovf_clr  input  1  clears the sticky overflow flag.
wen  output  1  RAM write enable = winc && !full (combinational).
waddr  output  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0].
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchroniser.
full  output  1  FIFO full (registered).
almost_full  output  1  occupancy >= afull_thresh (registered).
wcount  output  ADDR_WIDTH+1  write-side occupancy, 0..DEPTH (registered).
overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (async, rst_n=0): wbin, wptr_gray, all sync flops, full, almost_full, wcount, overflow = 0. Reset mid-operation takes effect immediately; no partial state survives.
- Pointer: wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1). Both are registered on posedge clk. wptr_gray changes at most one bit per clock.
- Sync: rq_rptr_gray passes through SYNC_STAGES flops, giving wq_rptr_gray. wq_rbin is the combinational Gray-to-binary of wq_rptr_gray.
- full register <= (wgray_next == {~wq_rptr_gray[AW:AW-1], wq_rptr_gray[AW-2:0]}). For ADDR_WIDTH=1 use {~wq_rptr_gray[1:0]}. The flag is computed from the next pointer, so full is high in the same cycle the DEPTH-th write completes. A write is never accepted while full.
- wcount register <= wbin_next - wq_rbin, modulo 2**(ADDR_WIDTH+1). Values range 0..DEPTH. wcount == DEPTH iff full.
- almost_full register <= (afull_thresh != 0) && (wcount_next >= afull_thresh). afull_thresh = 0 disables the flag. afull_thresh > DEPTH means the flag never asserts.
- overflow: set on the clock after any cycle with winc && full. Cleared by ovf_clr. If set and clear occur in the same cycle, set wins. Flag holds until cleared or reset.
- Read-side latency: a change on rq_rptr_gray captured at edge k reaches wq_rptr_gray at edge k+SYNC_STAGES-1. full, wcount and almost_full reflect it at edge k+SYNC_STAGES (pessimistic: full may deassert late, never early).
- Wrap-around: the MSB of wbin toggles every DEPTH writes. full/empty disambiguation relies on the MSB; wcount arithmetic is correct across wrap.
- Simultaneous write and read-pointer advance while full: wen=0 (write blocked). full drops only after the synced read pointer moves.
- winc held high while full: no pointer motion, wen=0, overflow sets once and stays set.

Test Plan:
- ADDR_WIDTH=3, read pointer held at 0, winc=1 for 10 cycles -> wen high for 8 cycles, waddr 0..7, wptr_gray sequence 0,1,3,2,6,7,5,4,C. full=1 after the 8th write edge, wcount=8, overflow=1 one cycle after the 9th request.
- After the case above, ovf_clr=1 with winc=1 in the same cycle -> overflow stays 1. Then ovf_clr=1 with winc=0 -> overflow=0 next edge.
- Full FIFO, rq_rptr_gray steps to Gray(3)=2 at edge k (SYNC_STAGES=2) -> full=0 and wcount=5 at edge k+2, not before.
- afull_thresh=6, fill from empty -> almost_full rises on the same edge wcount becomes 6. afull_thresh=0 -> almost_full stays 0 through a fill to full. afull_thresh=9 -> almost_full never asserts.
- Wrap: 20 write/read pairs with a concurrent read model -> wbin MSB toggles at writes 8 and 16, wcount never exceeds 8, no spurious full. Re-run with SYNC_STAGES=3, extending the flag latency by one cycle.
- Assert rst_n=0 mid-fill with wcount=5 -> all outputs 0 immediately. After release, the first write uses waddr=0.

Source files
------------

// File: rtl/wptr_full_if.sv
// Write-side bundle of the async FIFO pointer controller: user request, RAM write
// port, cross-domain Gray pointers, threshold and status flags.
interface wptr_full_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   rq_rptr_gray;
    logic [ADDR_WIDTH:0]   afull_thresh;
    logic                  ovf_clr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  overflow;

    modport master (
        output winc, rq_rptr_gray, afull_thresh, ovf_clr,
        input  wen, waddr, wptr_gray, full, almost_full, wcount, overflow
    );

    modport slave (
        input  winc, rq_rptr_gray, afull_thresh, ovf_clr,
        output wen, waddr, wptr_gray, full, almost_full, wcount, overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-domain controller: binary/Gray write pointer, read-pointer
// synchroniser, registered full / almost_full / occupancy and sticky overflow.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    wptr_full_if.slave bus
);
    localparam int AW = ADDR_WIDTH;
    // Inverting the top two Gray bits of the read pointer gives the Gray code of a
    // pointer exactly DEPTH ahead, i.e. the full position.
    localparam logic [AW:0] FULL_MASK = (AW + 1)'(3) << (AW - 1);

    logic [AW:0]                  wbin_q, wbin_d;
    logic [AW:0]                  wgray_q, wgray_d;
    logic [SYNC_STAGES-1:0][AW:0] rsync_q, rsync_d;
    logic                         full_q, full_d;
    logic                         afull_q, afull_d;
    logic [AW:0]                  wcount_q, wcount_d;
    logic                         ovf_q, ovf_d;
    logic                         wen;
    logic [AW:0]                  wq_rptr_gray;
    logic [AW:0]                  wq_rbin;

    always_comb begin
        rsync_d      = {rsync_q[SYNC_STAGES-2:0], bus.rq_rptr_gray};
        wq_rptr_gray = rsync_q[SYNC_STAGES-1];
        wq_rbin      = '0;
        for (int i = 0; i <= AW; i++) begin
            wq_rbin[i] = ^(wq_rptr_gray >> i);
        end
    end

    // Flags are derived from the next pointer so they register in the same edge
    // that completes the write.
    always_comb begin
        wen      = bus.winc && !full_q;
        wbin_d   = wbin_q + {{AW{1'b0}}, wen};
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        full_d   = (wgray_d == (wq_rptr_gray ^ FULL_MASK));
        wcount_d = wbin_d - wq_rbin;
        afull_d  = (bus.afull_thresh != '0) && (wcount_d >= bus.afull_thresh);
        ovf_d    = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.winc && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rsync_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wcount_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rsync_q  <= rsync_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            wcount_q <= wcount_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.wen         = wen;
    assign bus.waddr       = wbin_q[AW-1:0];
    assign bus.wptr_gray   = wgray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.wcount      = wcount_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: SYNC_STAGES=2 and 3 instances share one stimulus and
// are compared against expectations queued when the stimulus is driven.
module tb_wptr_full_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [AW:0]   gray;
        logic          full;
        logic          afull;
        logic [AW:0]   wcount;
        logic          ovf;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        winc;
    logic        ovf_clr;
    logic [AW:0] rq_rptr_gray;
    logic [AW:0] afull_thresh;
    int          errors = 0;
    int          checks = 0;
    snap_t       exp_q[$];

    wptr_full_if #(.ADDR_WIDTH(AW)) if2 ();
    wptr_full_if #(.ADDR_WIDTH(AW)) if3 ();

    assign if2.winc = winc;  assign if2.ovf_clr = ovf_clr;
    assign if2.rq_rptr_gray = rq_rptr_gray;  assign if2.afull_thresh = afull_thresh;
    assign if3.winc = winc;  assign if3.ovf_clr = ovf_clr;
    assign if3.rq_rptr_gray = rq_rptr_gray;  assign if3.afull_thresh = afull_thresh;

    wptr_full_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    wptr_full_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    always #5 clk = ~clk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = (AW + 1)'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic snap_t snap2();
        return '{if2.wen, if2.waddr, if2.wptr_gray, if2.full, if2.almost_full, if2.wcount, if2.overflow};
    endfunction

    function automatic snap_t snap3();
        return '{if3.wen, if3.waddr, if3.wptr_gray, if3.full, if3.almost_full, if3.wcount, if3.overflow};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("wen=%b waddr=%0d gray=%h full=%b afull=%b wcount=%0d ovf=%b",
                         s.wen, s.waddr, s.gray, s.full, s.afull, s.wcount, s.ovf);
    endfunction

    function automatic snap_t mk(input logic w, input int wb, input logic f, input logic af,
                                 input int wc, input logic ov);
        snap_t s;
        s.wen = w;  s.waddr = AW'(wb);  s.gray = gray(wb);  s.full = f;
        s.afull = af;  s.wcount = (AW + 1)'(wc);  s.ovf = ov;
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;  winc = 1'b0;  ovf_clr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        snap_t o;
        snap_t e;
        rst_n = 1'b0;  winc = 1'b0;  ovf_clr = 1'b0;
        rq_rptr_gray = '0;  afull_thresh = '0;
        #2;
        e = '0;
        o = snap2();  checks++;
        if (o !== e) begin errors++; $display("FAIL reset_ss2: got %s want %s", fmt(o), fmt(e)); end
        o = snap3();  checks++;
        if (o !== e) begin errors++; $display("FAIL reset_ss3: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // winc held for 10 cycles against an idle reader, then one idle cycle.
    task automatic test_fill_overflow();
        snap_t o;
        snap_t e;
        int    n;
        for (int i = 0; i < 11; i++) begin
            winc = (i < 10);
            n    = (i < DEPTH) ? i : DEPTH;
            exp_q.push_back(mk(winc && (i < DEPTH), n, i >= DEPTH, 1'b0, n, i >= DEPTH + 1));
            @(negedge clk);
            o = snap2();  e = exp_q.pop_front();  checks++;
            if (o !== e) begin errors++; $display("FAIL fill[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ovf_clr();
        snap_t o;
        snap_t e;
        winc = 1'b1;  ovf_clr = 1'b1;
        exp_q.push_back(mk(1'b0, DEPTH, 1'b1, 1'b0, DEPTH, 1'b1));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL clr_blocked: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        winc = 1'b0;
        exp_q.push_back(mk(1'b0, DEPTH, 1'b1, 1'b0, DEPTH, 1'b1));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL clr_set_wins: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        exp_q.push_back(mk(1'b0, DEPTH, 1'b1, 1'b0, DEPTH, 1'b0));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL clr_cleared: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
    endtask

    // Full FIFO; reader jumps to 3 while a blocked write is attempted.
    task automatic test_sync_latency();
        snap_t o;
        snap_t e;
        logic  f2, f3;
        for (int j = 0; j < 5; j++) begin
            rq_rptr_gray = gray(3);
            winc = (j == 0);
            f2 = (j < 3);
            f3 = (j < 4);
            exp_q.push_back(mk(1'b0, DEPTH, f2, 1'b0, f2 ? DEPTH : 5, j >= 1));
            exp_q.push_back(mk(1'b0, DEPTH, f3, 1'b0, f3 ? DEPTH : 5, j >= 1));
            @(negedge clk);
            o = snap2();  e = exp_q.pop_front();  checks++;
            if (o !== e) begin errors++; $display("FAIL sync_ss2[%0d]: got %s want %s", j, fmt(o), fmt(e)); end
            o = snap3();  e = exp_q.pop_front();  checks++;
            if (o !== e) begin errors++; $display("FAIL sync_ss3[%0d]: got %s want %s", j, fmt(o), fmt(e)); end
            @(posedge clk); #1;
        end
        winc = 1'b0;
    endtask

    task automatic test_almost_full();
        int    th_tab[4] = '{6, 0, 9, 8};
        snap_t o;
        snap_t e;
        int    n;
        for (int t = 0; t < 4; t++) begin
            rq_rptr_gray = '0;
            afull_thresh = (AW + 1)'(th_tab[t]);
            do_reset();
            for (int i = 0; i < 9; i++) begin
                winc = 1'b1;
                n    = (i < DEPTH) ? i : DEPTH;
                exp_q.push_back(mk(i < DEPTH, n, i >= DEPTH,
                                   (th_tab[t] != 0) && (n >= th_tab[t]), n, 1'b0));
                @(negedge clk);
                o = snap2();  e = exp_q.pop_front();  checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL afull_th%0d[%0d]: got %s want %s", th_tab[t], i, fmt(o), fmt(e));
                end
                @(posedge clk); #1;
            end
            winc = 1'b0;
        end
        afull_thresh = '0;
    endtask

    // Continuous writes with a reader trailing three entries behind; per-instance
    // model applies the synchroniser delay to the read pointer history.
    task automatic test_wrap();
        int    rhist[$];
        int    wb2, wb3, wc2, wc3, rb, r2, r3;
        snap_t o;
        snap_t e;
        rq_rptr_gray = '0;
        do_reset();
        wb2 = 0;  wb3 = 0;
        for (int c = 0; c < 20; c++) begin
            winc = 1'b1;
            rb   = (c >= 3) ? c - 3 : 0;
            rq_rptr_gray = gray(rb);
            rhist.push_back(rb);
            r2  = (c - 3 >= 0) ? rhist[c - 3] : 0;
            r3  = (c - 4 >= 0) ? rhist[c - 4] : 0;
            wc2 = (wb2 - r2) & 15;
            wc3 = (wb3 - r3) & 15;
            exp_q.push_back(mk(wc2 != DEPTH, wb2, wc2 == DEPTH, 1'b0, wc2, 1'b0));
            exp_q.push_back(mk(wc3 != DEPTH, wb3, wc3 == DEPTH, 1'b0, wc3, 1'b0));
            @(negedge clk);
            o = snap2();  e = exp_q.pop_front();  checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_ss2[%0d]: got %s want %s", c, fmt(o), fmt(e)); end
            o = snap3();  e = exp_q.pop_front();  checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_ss3[%0d]: got %s want %s", c, fmt(o), fmt(e)); end
            if (wc2 != DEPTH) wb2++;
            if (wc3 != DEPTH) wb3++;
            @(posedge clk); #1;
        end
        winc = 1'b0;
    endtask

    task automatic test_reset_midfill();
        snap_t o;
        snap_t e;
        rq_rptr_gray = '0;
        do_reset();
        winc = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        winc = 1'b0;
        exp_q.push_back(mk(1'b0, 5, 1'b0, 1'b0, 5, 1'b0));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL midfill_pre: got %s want %s", fmt(o), fmt(e)); end
        #1 rst_n = 1'b0;
        exp_q.push_back('0);
        #1;
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL midfill_rst: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        winc  = 1'b1;
        exp_q.push_back(mk(1'b1, 0, 1'b0, 1'b0, 0, 1'b0));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL midfill_first: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        winc = 1'b0;
        exp_q.push_back(mk(1'b0, 1, 1'b0, 1'b0, 1, 1'b0));
        @(negedge clk);
        o = snap2();  e = exp_q.pop_front();  checks++;
        if (o !== e) begin errors++; $display("FAIL midfill_after: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_ovf_clr();
        test_sync_latency();
        test_almost_full();
        test_wrap();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
